fetch_stage: RTL

Instruction-fetch stage with integrated IF/ID pipeline register. Holds the PC, drives the instruction-memory address, and predicts control flow using a direct-mapped BTB with 2-bit saturating counters. Captures {pc, instruction, prediction} into the IF/ID register for decode. Obeys pc_en, if_id_pipeline_en and if_id_pipeline_flush from the hazard unit, and redirects on modify_pc (mispredict) from execute.

---
 rtl/fetch_stage.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction-fetch stage with integrated IF/ID pipeline
//                register. Holds the PC, drives the instruction-memory
//                address and predicts control flow with a direct-mapped BTB
//                of 2-bit saturating counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC       = 32'h00000000,
    parameter int          BTB_INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_en,
    input  logic        if_id_pipeline_en,
    input  logic        if_id_pipeline_flush,
    input  logic        modify_pc,
    input  logic [31:0] ex_correct_pc,
    input  logic        ex_btb_update,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_taken,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic        id_pred_taken,
    output logic [31:0] id_pred_target,
    output logic        id_valid
);

    localparam int          c_ENTRIES = 1 << BTB_INDEX_BITS;
    localparam int          c_TAG_W   = 30 - BTB_INDEX_BITS;
    localparam logic [31:0] c_NOP     = 32'h00000013;

    // Counter encoding: bit 1 set means "predict taken"
    localparam logic [1:0] c_SNT = 2'b00;
    localparam logic [1:0] c_WNT = 2'b01;
    localparam logic [1:0] c_ST  = 2'b10;
    localparam logic [1:0] c_WT  = 2'b11;

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    logic [31:0]               r_pc;
    logic                      r_btb_valid  [c_ENTRIES];
    logic [c_TAG_W-1:0]        r_btb_tag    [c_ENTRIES];
    logic [31:0]               r_btb_target [c_ENTRIES];
    logic [1:0]                r_btb_state  [c_ENTRIES];

    logic [31:0]               r_id_pc;
    logic [31:0]               r_id_instr;
    logic                      r_id_pred_taken;
    logic [31:0]               r_id_pred_target;
    logic                      r_id_valid;

    // ------------------------------------------------------------------------
    // Counter transitions
    // ------------------------------------------------------------------------
    function automatic logic [1:0] f_ctr_taken(input logic [1:0] s);
        case (s)
            c_SNT:   f_ctr_taken = c_WNT;
            c_WNT:   f_ctr_taken = c_WT;
            c_WT:    f_ctr_taken = c_ST;
            default: f_ctr_taken = c_ST;
        endcase
    endfunction

    function automatic logic [1:0] f_ctr_not_taken(input logic [1:0] s);
        case (s)
            c_ST:    f_ctr_not_taken = c_WT;
            c_WT:    f_ctr_not_taken = c_WNT;
            c_WNT:   f_ctr_not_taken = c_SNT;
            default: f_ctr_not_taken = c_SNT;
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // Lookup side (current PC)
    // ------------------------------------------------------------------------
    logic [BTB_INDEX_BITS-1:0] w_lk_idx;
    logic [c_TAG_W-1:0]        w_lk_tag;
    logic                      w_lk_hit;
    logic                      w_pred_taken;
    logic [31:0]               w_pred_target;

    assign w_lk_idx      = r_pc[BTB_INDEX_BITS+1:2];
    assign w_lk_tag      = r_pc[31:BTB_INDEX_BITS+2];
    assign w_lk_hit      = r_btb_valid[w_lk_idx] && (r_btb_tag[w_lk_idx] == w_lk_tag);
    assign w_pred_taken  = w_lk_hit && r_btb_state[w_lk_idx][1];
    assign w_pred_target = r_btb_target[w_lk_idx];

    // ------------------------------------------------------------------------
    // Update side (resolved branch from execute)
    // ------------------------------------------------------------------------
    logic [BTB_INDEX_BITS-1:0] w_upd_idx;
    logic [c_TAG_W-1:0]        w_upd_tag;
    logic                      w_upd_hit;
    logic                      w_upd_we;
    logic [1:0]                w_upd_state;
    logic [31:0]               w_upd_target;
    logic                      w_unused_ex_pc_lsbs;

    assign w_upd_idx = ex_pc[BTB_INDEX_BITS+1:2];
    assign w_upd_tag = ex_pc[31:BTB_INDEX_BITS+2];
    assign w_upd_hit = r_btb_valid[w_upd_idx] && (r_btb_tag[w_upd_idx] == w_upd_tag);
    // A not-taken miss leaves the table untouched
    assign w_upd_we  = ex_btb_update && (w_upd_hit || ex_taken);

    // The byte offset of an instruction address carries no BTB information
    assign w_unused_ex_pc_lsbs = ^ex_pc[1:0];

    // Select the state/target written for a hit-update or a fresh allocation
    always_comb begin
        w_upd_state  = c_WT;
        w_upd_target = ex_target;
        if (w_upd_hit) begin
            if (ex_taken) begin
                w_upd_state  = f_ctr_taken(r_btb_state[w_upd_idx]);
                w_upd_target = ex_target;
            end else begin
                w_upd_state  = f_ctr_not_taken(r_btb_state[w_upd_idx]);
                w_upd_target = r_btb_target[w_upd_idx];
            end
        end
    end

    // BTB table; same-cycle lookups see the pre-update contents
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_ENTRIES; i++) begin
                r_btb_valid[i]  <= 1'b0;
                r_btb_tag[i]    <= '0;
                r_btb_target[i] <= '0;
                r_btb_state[i]  <= c_SNT;
            end
        end else if (w_upd_we) begin
            r_btb_valid[w_upd_idx]  <= 1'b1;
            r_btb_tag[w_upd_idx]    <= w_upd_tag;
            r_btb_target[w_upd_idx] <= w_upd_target;
            r_btb_state[w_upd_idx]  <= w_upd_state;
        end
    end

    // ------------------------------------------------------------------------
    // Program counter
    // ------------------------------------------------------------------------
    logic [31:0] w_next_pc;

    // Next-PC priority: redirect, stall, predicted target, sequential
    always_comb begin
        w_next_pc = r_pc + 32'd4;
        if (modify_pc) begin
            w_next_pc = ex_correct_pc;
        end else if (!pc_en) begin
            w_next_pc = r_pc;
        end else if (w_pred_taken) begin
            w_next_pc = w_pred_target;
        end
    end

    // PC register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_next_pc;
        end
    end

    assign imem_addr = r_pc;

    // ------------------------------------------------------------------------
    // IF/ID pipeline register; flush outranks enable
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || if_id_pipeline_flush) begin
            r_id_pc          <= 32'h0;
            r_id_instr       <= c_NOP;
            r_id_pred_taken  <= 1'b0;
            r_id_pred_target <= 32'h0;
            r_id_valid       <= 1'b0;
        end else if (if_id_pipeline_en) begin
            r_id_pc          <= r_pc;
            r_id_instr       <= imem_rdata;
            r_id_pred_taken  <= w_pred_taken;
            r_id_pred_target <= w_pred_taken ? w_pred_target : 32'h0;
            r_id_valid       <= 1'b1;
        end
    end

    assign id_pc          = r_id_pc;
    assign id_instr       = r_id_instr;
    assign id_pred_taken  = r_id_pred_taken;
    assign id_pred_target = r_id_pred_target;
    assign id_valid       = r_id_valid;

endmodule
`default_nettype wire
